// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory port.
// Serves a byte-lane-writable data RAM (region 0x1xxx_xxxx) and a small
// MMIO window (region 0x8xxx_xxxx) with status, a TX byte FIFO and
// performance counters. Any other region is unmapped and sets a sticky error.
// Optional feature macro: DMEM_COUNTERS_EN builds the cycle/retired counters
// and their clear register; without it those offsets read 0.
module dmem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wen,
    input  logic        req_ren,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic        inst_retired,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_AW  = $clog2(DEPTH_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    // MMIO word offsets (byte offset / 4)
    localparam logic [25:0] OFF_STATUS  = 26'h0;
    localparam logic [25:0] OFF_TXDATA  = 26'h2;
    localparam logic [25:0] OFF_CYCLE   = 26'h4;
    localparam logic [25:0] OFF_RETIRED = 26'h5;
    localparam logic [25:0] OFF_CNT_CLR = 26'h6;
    localparam logic [25:0] OFF_ERR_CLR = 26'h7;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        is_ram;
    logic        is_mmio;
    logic        is_unmapped;
    logic        any_wen;
    logic        mmio_wr;
    logic [25:0] mmio_off;

    assign is_ram      = (req_addr[31:28] == 4'h1);
    assign is_mmio     = (req_addr[31:28] == 4'h8);
    assign is_unmapped = !is_ram && !is_mmio;
    assign any_wen     = |req_wen;
    assign mmio_off    = req_addr[27:2];
    // A request presented while rst is high has no side effects.
    assign mmio_wr     = !rst && is_mmio && any_wen;

    // Byte-offset bits within a word never select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    // ------------------------------------------------------------------
    // Data RAM: byte-lane writes, registered read-first read port
    // ------------------------------------------------------------------
    logic [31:0]       ram_mem [DEPTH_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_rd_q;
    logic              ram_rd;
    logic              ram_wr;

    // Upper region bits are ignored, so the index wraps modulo DEPTH_WORDS.
    assign ram_idx = req_addr[RAM_AW+1:2];
    assign ram_rd  = !rst && req_ren && is_ram;
    assign ram_wr  = !rst && is_ram;

    // RAM port: read sees the pre-write word, enabled lanes are written.
    always_ff @(posedge clk) begin
        if (ram_rd) begin
            ram_rd_q <= ram_mem[ram_idx];
        end
        for (int i = 0; i < 4; i++) begin
            if (ram_wr && req_wen[i]) begin
                ram_mem[ram_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // TX byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]   wr_ptr_q;
    logic [FIFO_AW:0]   wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q;
    logic [FIFO_AW:0]   rd_ptr_d;
    logic [FIFO_AW-1:0] wr_idx;
    logic [FIFO_AW-1:0] head_idx_d;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic [7:0]         tx_data_q;
    logic [7:0]         tx_data_d;
    logic               tx_valid_q;
    logic               tx_valid_d;

    assign wr_idx     = wr_ptr_q[FIFO_AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop        = tx_valid_q && tx_ready;
    assign push_req   = mmio_wr && (mmio_off == OFF_TXDATA) && req_wen[0];
    // A pop in the same cycle frees the slot, so a push to a full FIFO is
    // still accepted when the head is draining.
    assign push_ok    = push_req && (!fifo_full || pop);

    // FIFO pointer advance and the head byte that the output registers load.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        head_idx_d = rd_ptr_d[FIFO_AW-1:0];
        // The byte being pushed becomes the head when it lands in the head
        // slot; forward it because the storage write lands at the same edge.
        if (push_ok && (wr_idx == head_idx_d)) begin
            tx_data_d = req_wdata[7:0];
        end else begin
            tx_data_d = fifo_mem[head_idx_d];
        end
        tx_valid_d = (wr_ptr_d != rd_ptr_d);
    end

    // FIFO storage; contents are meaningless outside the pointer window.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_idx] <= req_wdata[7:0];
        end
    end

    // FIFO pointers and registered drain-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

    // ------------------------------------------------------------------
    // Sticky error
    // ------------------------------------------------------------------
    logic err_q;
    logic err_d;
    logic err_set;
    logic err_clr;

    assign err_set = !rst && ((is_unmapped && (req_ren || any_wen)) ||
                              (push_req && fifo_full && !pop));
    assign err_clr = mmio_wr && (mmio_off == OFF_ERR_CLR);

    // Set has priority over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] cycle_count;
    logic [31:0] retired_count;

`ifdef DMEM_COUNTERS_EN
    logic [31:0] cyc_q;
    logic [31:0] cyc_d;
    logic [31:0] ret_q;
    logic [31:0] ret_d;
    logic        cnt_clr;

    assign cnt_clr = mmio_wr && (mmio_off == OFF_CNT_CLR);

    // Counter increments; a clear in the same cycle wins.
    always_comb begin
        cyc_d = cyc_q + 32'd1;
        ret_d = ret_q + {31'd0, inst_retired};
        if (cnt_clr) begin
            cyc_d = '0;
            ret_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_count   = cyc_q;
    assign retired_count = ret_q;
`else
    assign cycle_count   = '0;
    assign retired_count = '0;

    logic unused_retired;
    assign unused_retired = inst_retired;
`endif

    // ------------------------------------------------------------------
    // Read response path
    // ------------------------------------------------------------------
    logic [31:0] mmio_rd_d;
    logic [31:0] mmio_rd_q;
    logic        src_ram_q;
    logic        rdata_valid_q;

    // MMIO/unmapped read value, sampled from pre-edge state.
    always_comb begin
        mmio_rd_d = '0;
        if (is_mmio) begin
            case (mmio_off)
                OFF_STATUS:  mmio_rd_d = {29'd0, err_q, fifo_empty, !fifo_full};
                OFF_CYCLE:   mmio_rd_d = cycle_count;
                OFF_RETIRED: mmio_rd_d = retired_count;
                default:     mmio_rd_d = '0;
            endcase
        end
    end

    // Response bookkeeping: which source holds the last read and its validity.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_valid_q <= 1'b0;
            src_ram_q     <= 1'b0;
            mmio_rd_q     <= '0;
        end else begin
            rdata_valid_q <= req_ren;
            if (req_ren) begin
                src_ram_q <= is_ram;
                if (!is_ram) begin
                    mmio_rd_q <= mmio_rd_d;
                end
            end
        end
    end

    // Both sources hold their value between reads, so rdata holds too.
    assign rdata       = src_ram_q ? ram_rd_q : mmio_rd_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + randomized checks of dmem_responder
// against a queue/array reference model of the memory-port rules.
module tb_dmem_responder;

    localparam int DEPTH = 4096;
    localparam int FD    = 4;
`ifdef DMEM_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wen = '0;
    logic        req_ren = 1'b0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        inst_retired = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wen(req_wen),
        .req_ren(req_ren), .rdata(rdata), .rdata_valid(rdata_valid),
        .inst_retired(inst_retired), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] ram_m [int];
    logic [7:0]  fifo_m [$];
    logic        err_m = 1'b0;
    logic [31:0] cyc_m = '0;
    logic [31:0] ret_m = '0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_rdata = '0;
    bit          exp_known = 1'b0;
    bit          m_ready = 1'b0;
    logic        rdy_g = 1'b0;
    logic [7:0]  last_byte = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        int idx;
        logic [27:0] off;
        known = 1'b1;
        off = a[27:0] & 28'hFFF_FFFC;
        if (a[31:28] == 4'h1) begin
            idx = int'((a >> 2) & (DEPTH - 1));
            if (ram_m.exists(idx)) return ram_m[idx];
            known = 1'b0;
            return 32'h0;
        end
        if (a[31:28] == 4'h8) begin
            if (off == 28'h0)
                return {29'd0, err_m, fifo_m.size() == 0, fifo_m.size() < FD};
            if (off == 28'h10) return CNT_EN ? cyc_m : 32'h0;
            if (off == 28'h14) return CNT_EN ? ret_m : 32'h0;
        end
        return 32'h0;
    endfunction

    // One clock cycle: drive, check pre-edge outputs, advance model, check response.
    task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic re, input logic ret, input logic rdy);
        bit pop, known, set_e, clr_e, clr_c, push_f;
        logic [31:0] rv, w;
        logic [27:0] off;
        int idx;
        rst = r; req_addr = a; req_wdata = wd; req_wen = we; req_ren = re;
        inst_retired = ret; tx_ready = rdy;
        if (m_ready) begin
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, fifo_m.size() != 0});
            if (fifo_m.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, fifo_m[0]});
            if (tx_valid && rdy) last_byte = tx_data;
        end
        if (r) begin
            fifo_m.delete(); err_m = 1'b0; cyc_m = '0; ret_m = '0;
            exp_valid = 1'b0; exp_rdata = '0; exp_known = 1'b1;
        end else begin
            pop = (fifo_m.size() != 0) && rdy;
            off = a[27:0] & 28'hFFF_FFFC;
            if (re) begin
                rv = model_read(a, known);
                exp_valid = 1'b1;
                exp_known = known;
                if (known) exp_rdata = rv;
            end else begin
                exp_valid = 1'b0;
            end
            set_e = (a[31:28] != 4'h1) && (a[31:28] != 4'h8) && (re || we != 4'h0);
            clr_e = 1'b0; clr_c = 1'b0; push_f = 1'b0;
            if (a[31:28] == 4'h1) begin
                idx = int'((a >> 2) & (DEPTH - 1));
                if (ram_m.exists(idx) || we == 4'hF) begin
                    w = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
                    for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
                    ram_m[idx] = w;
                end
            end
            if (a[31:28] == 4'h8 && we != 4'h0) begin
                if (off == 28'h8 && we[0]) begin
                    if (fifo_m.size() < FD || pop) push_f = 1'b1;
                    else set_e = 1'b1;
                end
                if (off == 28'h18) clr_c = CNT_EN;
                if (off == 28'h1C) clr_e = 1'b1;
            end
            if (pop) void'(fifo_m.pop_front());
            if (push_f) fifo_m.push_back(wd[7:0]);
            err_m = set_e ? 1'b1 : (clr_e ? 1'b0 : err_m);
            if (CNT_EN) begin
                cyc_m = clr_c ? 32'h0 : cyc_m + 32'd1;
                ret_m = clr_c ? 32'h0 : ret_m + {31'd0, ret};
            end
        end
        @(posedge clk);
        #1;
        if (r) m_ready = 1'b1;
        chk("rdata_valid", {31'd0, rdata_valid}, {31'd0, exp_valid});
        if (exp_known) chk("rdata", rdata, exp_rdata);
    endtask

    task automatic idle(input logic ret);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, ret, rdy_g);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        cyc(1'b0, a, d, we, 1'b0, 1'b0, rdy_g);
    endtask
    task automatic rd(input logic [31:0] a);
        cyc(1'b0, a, 32'h0, 4'h0, 1'b1, 1'b0, rdy_g);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0] we;
        int kind;
        logic [31:0] offs [8];
        offs = '{32'h0, 32'h8, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h4};

        @(posedge clk);
        #1;
        // Reset state
        cyc(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("reset_tx_data", {24'd0, tx_data}, 32'h0);

        // Counters: 10 cycles with 3 retire pulses
        for (int i = 0; i < 10; i++) idle((i == 2 || i == 5 || i == 7) ? 1'b1 : 1'b0);
        rd(32'h8000_0010);
        chk("cycle_cnt_10", rdata, CNT_EN ? 32'd10 : 32'd0);
        rd(32'h8000_0014);
        chk("retired_cnt_3", rdata, CNT_EN ? 32'd3 : 32'd0);

        // RAM byte lanes
        wr(32'h1000_0000, 32'hAABB_CCDD, 4'hF);
        wr(32'h1000_0000, 32'h0011_0000, 4'b0100);
        rd(32'h1000_0000);
        chk("lane_merge", rdata, 32'hAA11_CCDD);
        chk("lane_merge_valid", {31'd0, rdata_valid}, 32'd1);
        idle(1'b0);
        chk("valid_drops", {31'd0, rdata_valid}, 32'd0);
        chk("rdata_holds", rdata, 32'hAA11_CCDD);

        // Read-first collision
        wr(32'h1000_0040, 32'h1, 4'hF);
        cyc(1'b0, 32'h1000_0040, 32'h2, 4'hF, 1'b1, 1'b0, 1'b0);
        chk("read_first_old", rdata, 32'h1);
        rd(32'h1000_0040);
        chk("read_first_new", rdata, 32'h2);

        // FIFO fill and overflow
        rdy_g = 1'b0;
        for (int i = 0; i < 5; i++) wr(32'h8000_0008, 32'h41 + i, 4'h1);
        wr(32'h8000_0008, 32'h99, 4'h2);   // wen[0]=0: ignored
        rd(32'h8000_0000);
        chk("status_overflow", rdata, 32'h4);
        wr(32'h8000_001C, 32'h0, 4'hF);
        rdy_g = 1'b1;
        for (int i = 0; i < 5; i++) idle(1'b0);
        chk("drained_empty", {31'd0, tx_valid}, 32'd0);
        chk("drain_last", {24'd0, last_byte}, 32'h44);

        // Full push + pop in the same cycle
        rdy_g = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h8000_0008, 32'h50 + i, 4'h1);
        cyc(1'b0, 32'h8000_0008, 32'h5A, 4'h1, 1'b0, 1'b0, 1'b1);
        rd(32'h8000_0000);
        chk("pushpop_status", rdata, 32'h0);
        rdy_g = 1'b1;
        for (int i = 0; i < 5; i++) idle(1'b0);
        chk("pushpop_last", {24'd0, last_byte}, 32'h5A);

        // Counter clear concurrent with retire pulse
        cyc(1'b0, 32'h8000_0018, 32'h0, 4'h1, 1'b0, 1'b1, rdy_g);
        rd(32'h8000_0010);
        chk("cnt_clr_cycle", rdata, 32'h0);
        rd(32'h8000_0014);
        chk("cnt_clr_retired", rdata, 32'h0);

        // Unmapped access and error clear
        rd(32'h4000_0000);
        chk("unmapped_rdata", rdata, 32'h0);
        rd(32'h8000_0000);
        chk("unmapped_err", rdata & 32'h4, 32'h4);
        wr(32'h8000_001C, 32'h0, 4'h8);
        rd(32'h8000_0000);
        chk("err_cleared", rdata & 32'h4, 32'h0);

        // Reset mid-operation: FIFO contents lost, read discarded
        rdy_g = 1'b0;
        wr(32'h8000_0008, 32'h77, 4'h1);
        cyc(1'b1, 32'h1000_0000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("reset_read_dropped", {31'd0, rdata_valid}, 32'd0);
        chk("reset_fifo_lost", {31'd0, tx_valid}, 32'd0);
        rd(32'h1000_0000);
        chk("ram_survives_reset", rdata, 32'hAA11_CCDD);

        // Randomized phase over a small set of wrapped RAM words and MMIO
        for (int i = 0; i < 8; i++) wr(32'h1000_0000 + 4 * i, $urandom, 4'hF);
        for (int n = 0; n < 500; n++) begin
            kind = $urandom_range(0, 19);
            we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            d = $urandom;
            if (kind < 9)
                a = {4'h1, 14'($urandom), 9'd0, 3'($urandom), 2'($urandom)};
            else if (kind < 17)
                a = 32'h8000_0000 | offs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            else if (kind == 17)
                a = {4'h3, 28'($urandom)};
            else
                a = 32'h0;
            if (kind > 17) we = 4'h0;
            cyc(1'b0, a, d, we, (kind > 17) ? 1'b0 : 1'($urandom),
                1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
